// File: rtl/epu_wsram_pkg.sv
// Shared types and helpers for the EPU banked weight store.
// Burst state encoding, bank index width and sign extension.
package epu_wsram_pkg;

    typedef enum logic [1:0] {
        BST_IDLE,
        BST_RUN,
        BST_DRAIN
    } bst_state_t;

    function automatic int bank_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [63:0] sign_extend(
        input logic [63:0] d,
        input int          w
    );
        logic [63:0] r;
        r = d;
        for (int i = 0; i < 64; i++) begin
            if (i >= w) r[i] = d[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_sram_banked_bank.sv
// One single-port bank macro wrapper; enables itself only when the
// decoded bank index matches its own position.
module wsram_bank
    import epu_wsram_pkg::*;
#(
    parameter int DEPTH   = 16384,
    parameter int DATA_W  = 18,
    parameter int IDX_W   = 3,
    parameter int BANK_ID = 0
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [IDX_W-1:0]         idx,
    input  logic [$clog2(DEPTH)-1:0] offset,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              cs_b;
    logic              web;
    logic              oe;

    assign cs_b = en && (idx == IDX_W'(BANK_ID));
    assign web  = ~(cs_b & we);
    assign oe   = cs_b & ~we;

    always_ff @(posedge clk) begin
        if (!web) mem[offset] <= wdata;
        if (oe)   rdata <= mem[offset];
    end

endmodule

// File: rtl/weight_sram_banked.sv
// Banked weight store with host port and streaming burst-read engine.
// WSRAM_OUT_REG_EN adds an output register stage and a 3-entry burst FIFO.
module weight_sram_banked
    import epu_wsram_pkg::*;
#(
    parameter int NUM_BANKS  = 5,
    parameter int BANK_DEPTH = 16384,
    parameter int DATA_W     = 18,
    parameter int OUT_W      = 32,
    parameter int ADDR_W     = 17,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [OUT_W-1:0]  rdata,
    output logic              rvalid,
    output logic              addr_err,
    input  logic              bst_start,
    input  logic [ADDR_W-1:0] bst_base,
    input  logic [LEN_W-1:0]  bst_len,
    output logic [OUT_W-1:0]  bst_data,
    output logic              bst_valid,
    input  logic              bst_ready,
    output logic              bst_busy,
    output logic              bst_done
);

    localparam int OFF_W = $clog2(BANK_DEPTH);
    localparam int IDX_W = bank_idx_w(NUM_BANKS);
`ifdef WSRAM_OUT_REG_EN
    localparam int FD = 3;
`else
    localparam int FD = 2;
`endif

    bst_state_t        state, state_n;
    logic [ADDR_W-1:0] bst_addr;
    logic [LEN_W-1:0]  bst_rem;
    logic              zero_q, zero_d;

    logic [1:0]        fifo_cnt, infl, wr_ptr, rd_ptr;
    logic [OUT_W-1:0]  fifo_mem [4];

    logic              bst_issue, acc_en, in_range;
    logic [ADDR_W-1:0] acc_addr, bank_full;
    logic [IDX_W-1:0]  idx, sel_idx_q;
    logic              sel_ok_q, rd_host_q, rd_bst_q, err_q;
    logic [DATA_W-1:0] bank_rd [NUM_BANKS];
    logic [DATA_W-1:0] mux_data;
    logic [OUT_W-1:0]  ext, host_d, push_data;
    logic              host_v, push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FD - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Host access always wins the single shared bank port.
    assign bst_issue = (state == BST_RUN) && !cs &&
                       (({1'b0, fifo_cnt} + {1'b0, infl}) < 3'(FD));
    assign acc_en    = cs | bst_issue;
    assign acc_addr  = cs ? addr : bst_addr;
    assign bank_full = acc_addr >> OFF_W;
    assign in_range  = bank_full < ADDR_W'(NUM_BANKS);
    assign idx       = bank_full[IDX_W-1:0];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        wsram_bank #(
            .DEPTH   (BANK_DEPTH),
            .DATA_W  (DATA_W),
            .IDX_W   (IDX_W),
            .BANK_ID (b)
        ) u_bank (
            .clk    (clk),
            .en     (acc_en & in_range),
            .we     (cs & we),
            .idx    (idx),
            .offset (acc_addr[OFF_W-1:0]),
            .wdata  (wdata),
            .rdata  (bank_rd[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_idx_q <= '0;
            sel_ok_q  <= 1'b0;
            rd_host_q <= 1'b0;
            rd_bst_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sel_idx_q <= idx;
            sel_ok_q  <= acc_en & in_range;
            rd_host_q <= cs & ~we;
            rd_bst_q  <= bst_issue;
            err_q     <= acc_en & ~in_range;
        end
    end

    always_comb begin
        mux_data = '0;
        if (sel_ok_q) mux_data = bank_rd[sel_idx_q];
    end

    assign ext = OUT_W'(sign_extend(64'(mux_data), DATA_W));

`ifdef WSRAM_OUT_REG_EN
    logic [OUT_W-1:0] out_q;
    logic             rd_host_q2, rd_bst_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            rd_host_q2 <= 1'b0;
            rd_bst_q2  <= 1'b0;
        end else begin
            out_q      <= ext;
            rd_host_q2 <= rd_host_q;
            rd_bst_q2  <= rd_bst_q;
        end
    end

    assign host_v    = rd_host_q2;
    assign host_d    = out_q;
    assign push      = rd_bst_q2;
    assign push_data = out_q;
`else
    assign host_v    = rd_host_q;
    assign host_d    = ext;
    assign push      = rd_bst_q;
    assign push_data = ext;
`endif

    assign rvalid   = host_v;
    assign rdata    = host_v ? host_d : '0;
    assign addr_err = err_q;

    assign bst_valid = fifo_cnt != 2'd0;
    assign pop       = bst_valid & bst_ready;
    assign bst_data  = bst_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            infl     <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            infl     <= infl + {1'b0, bst_issue} - {1'b0, push};
        end
    end

    always_comb begin
        state_n = state;
        zero_d  = 1'b0;
        unique case (state)
            BST_IDLE: begin
                if (bst_start) begin
                    if (bst_len != '0) state_n = BST_RUN;
                    else               zero_d  = 1'b1;
                end
            end
            BST_RUN: begin
                if (bst_issue && bst_rem == LEN_W'(1)) state_n = BST_DRAIN;
            end
            BST_DRAIN: begin
                if (fifo_cnt == '0 && infl == '0) state_n = BST_IDLE;
            end
            default: state_n = BST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BST_IDLE;
            bst_addr <= '0;
            bst_rem  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state  <= state_n;
            zero_q <= zero_d;
            if (state == BST_IDLE && bst_start) begin
                bst_addr <= bst_base;
                bst_rem  <= bst_len;
            end else if (bst_issue) begin
                bst_addr <= bst_addr + ADDR_W'(1);
                bst_rem  <= bst_rem - LEN_W'(1);
            end
        end
    end

    assign bst_busy = state != BST_IDLE;
    assign bst_done = zero_q |
                      (state == BST_DRAIN && fifo_cnt == '0 && infl == '0);

endmodule

// File: tb/tb_weight_sram_banked.sv
// Self-checking bench for weight_sram_banked (default build).
// Word-level memory model plus expected burst queue.
module tb_weight_sram_banked;

    localparam int NB  = 5;
    localparam int BD  = 16384;
    localparam int DW  = 18;
    localparam int OW  = 32;
    localparam int AW  = 17;
    localparam int LW  = 16;
    localparam int LIM = NB * BD;

    logic          clk;
    logic          rst;
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [OW-1:0] rdata;
    logic          rvalid;
    logic          addr_err;
    logic          bst_start;
    logic [AW-1:0] bst_base;
    logic [LW-1:0] bst_len;
    logic [OW-1:0] bst_data;
    logic          bst_valid;
    logic          bst_ready;
    logic          bst_busy;
    logic          bst_done;

    weight_sram_banked #(
        .NUM_BANKS  (NB),
        .BANK_DEPTH (BD),
        .DATA_W     (DW),
        .OUT_W      (OW),
        .ADDR_W     (AW),
        .LEN_W      (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .addr_err  (addr_err),
        .bst_start (bst_start),
        .bst_base  (bst_base),
        .bst_len   (bst_len),
        .bst_data  (bst_data),
        .bst_valid (bst_valid),
        .bst_ready (bst_ready),
        .bst_busy  (bst_busy),
        .bst_done  (bst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -10;
    int done_cnt = 0;
    int nacc  = 0;
    int berr  = 0;
    bit in_burst = 1'b0;
    bit zl = 1'b0;

    logic [DW-1:0] mem_m [int];
    logic [OW-1:0] bq [$];
    logic          e_rv  = 1'b0;
    logic          e_err = 1'b0;
    logic [OW-1:0] e_rd  = '0;

    function automatic logic [OW-1:0] exp_word(input int a);
        if (a >= LIM || !mem_m.exists(a)) return '0;
        return OW'($signed(mem_m[a]));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: reads return the pre-write contents, one cycle later.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            e_rv  = 1'b0;
            e_err = 1'b0;
            e_rd  = '0;
        end else begin
            e_rv  = cs && !we;
            e_rd  = (cs && !we) ? exp_word(int'(addr)) : '0;
            e_err = cs && (int'(addr) >= LIM);
            if (cs && we && int'(addr) < LIM) mem_m[int'(addr)] = wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rvalid", {31'd0, rvalid}, {31'd0, e_rv});
            if (e_rv) chk("rdata", rdata, e_rd);
            if (!in_burst) chk("addr_err", {31'd0, addr_err}, {31'd0, e_err});
            else if (addr_err) berr++;
            if (bst_valid && bst_ready) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_extra act=%h exp=none", bst_data);
                end else begin
                    chk("beat", bst_data, bq.pop_front());
                end
                last_acc = cyc;
                nacc++;
            end
            if (bst_done) begin
                done_cnt++;
                chk("done_q_empty", bq.size(), 0);
                if (!zl) chk("done_time", cyc, last_acc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d);
        cs = 1'b1; we = 1'b1; addr = AW'(a); wdata = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic host_read(input int a);
        cs = 1'b1; we = 1'b0; addr = AW'(a);
        tick();
        cs = 1'b0;
    endtask

    task automatic start_burst(input int base, input int len);
        for (int i = 0; i < len; i++) bq.push_back(exp_word(base + i));
        nacc = 0;
        bst_start = 1'b1; bst_base = AW'(base); bst_len = LW'(len);
        tick();
        bst_start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input bit toggle);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > d0) break;
            if (toggle) bst_ready = ~bst_ready;
            tick();
        end
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    int d0;

    initial begin
        rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        bst_start = 1'b0; bst_base = '0; bst_len = '0; bst_ready = 1'b1;
        tick();
        tick();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
        chk("rst_err", {31'd0, addr_err}, 32'h0);
        chk("rst_bdata", bst_data, 32'h0);
        chk("rst_bvalid", {31'd0, bst_valid}, 32'h0);
        chk("rst_busy", {31'd0, bst_busy}, 32'h0);
        chk("rst_done", {31'd0, bst_done}, 32'h0);
        rst = 1'b0;
        tick();

        host_write(16383, 18'h3FFFF);
        host_write(16384, 18'h00123);
        host_write(16382, 18'h10005);
        host_write(16385, 18'h28000);
        host_write(3, 18'h00007);
        host_write(LIM - 2, 18'h00ABC);
        host_write(LIM - 1, 18'h3FFFE);
        for (int i = 0; i < 8; i++) host_write(100 + i, DW'(i * 37 + 'h20000 * (i % 2)));

        host_read(16383);
        chk("lit_rv", {31'd0, rvalid}, 32'h1);
        chk("lit_ffff", rdata, 32'hFFFFFFFF);
        host_read(16384);
        chk("lit_123", rdata, 32'h00000123);
        host_read(16385);
        chk("lit_neg", rdata, 32'hFFFE8000);
        host_read(LIM);
        chk("oor_rdata", rdata, 32'h0);
        chk("oor_err", {31'd0, addr_err}, 32'h1);
        tick();
        chk("oor_err_pulse", {31'd0, addr_err}, 32'h0);
        host_write(LIM + 3, 18'h3FFFF);
        host_read(3);
        chk("oor_nowrite", rdata, 32'h00000007);
        tick();

        in_burst = 1'b1;
        d0 = done_cnt;
        start_burst(16382, 4);
        wait_done(d0, 1'b0);
        chk("b4_acc", nacc, 4);
        chk("b4_busy", {31'd0, bst_busy}, 32'h0);
        tick();

        d0 = done_cnt;
        start_burst(100, 8);
        for (int i = 0; i < 3; i++) begin
            bst_ready = ~bst_ready;
            tick();
        end
        host_read(16384);
        chk("mid_host", rdata, 32'h00000123);
        wait_done(d0, 1'b1);
        chk("b8_acc", nacc, 8);
        bst_ready = 1'b1;
        tick();

        berr = 0;
        d0 = done_cnt;
        start_burst(LIM - 2, 4);
        wait_done(d0, 1'b0);
        chk("oor_b_acc", nacc, 4);
        chk("oor_b_err", berr, 2);
        tick();

        zl = 1'b1;
        d0 = done_cnt;
        bst_start = 1'b1; bst_base = AW'(5); bst_len = '0;
        tick();
        bst_start = 1'b0;
        chk("zero_done", {31'd0, bst_done}, 32'h1);
        chk("zero_busy", {31'd0, bst_busy}, 32'h0);
        tick();
        chk("zero_done_pulse", {31'd0, bst_done}, 32'h0);
        chk("zero_cnt", done_cnt, d0 + 1);
        zl = 1'b0;

        bst_ready = 1'b0;
        start_burst(100, 8);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mr_rdata", rdata, 32'h0);
        chk("mr_rvalid", {31'd0, rvalid}, 32'h0);
        chk("mr_bdata", bst_data, 32'h0);
        chk("mr_bvalid", {31'd0, bst_valid}, 32'h0);
        chk("mr_busy", {31'd0, bst_busy}, 32'h0);
        chk("mr_done", {31'd0, bst_done}, 32'h0);
        rst = 1'b0;
        bq.delete();
        bst_ready = 1'b1;
        tick();
        d0 = done_cnt;
        start_burst(16382, 2);
        wait_done(d0, 1'b0);
        chk("mr_b2_acc", nacc, 2);
        in_burst = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
